// File: rtl/serial_lcd_formatter_if.sv
// Receiver-to-LCD link: byte handshake from the UART receiver and the
// {RS,data} write port towards the character-LCD driver.
interface serial_lcd_formatter_if;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rd_ack;
    logic [8:0] data_out;
    logic       wr_en;

    modport master (
        output rx_data, rx_rdy,
        input  rd_ack, data_out, wr_en
    );

    modport slave (
        input  rx_data, rx_rdy,
        output rd_ack, data_out, wr_en
    );
endinterface

// File: rtl/serial_lcd_formatter.sv
// Turns received bytes into paced LCD write words, handling CR/LF/BS/FF
// and tracking the cursor with line wrap on a two-row display.
module serial_lcd_formatter #(
    parameter int COLS    = 16,
    parameter int GAP     = 2500,
    parameter int CLR_GAP = 100000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    serial_lcd_formatter_if.slave lcd_if,
    output logic [3:0]           col_o,
    output logic                 row_o,
    output logic                 busy_o
);
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ACK, S_DECODE, S_EMIT, S_WAIT} state_t;

    localparam logic [19:0] GAP_W  = 20'(GAP);
    localparam logic [19:0] CLR_W  = 20'(CLR_GAP);
    localparam logic [4:0]  COLS_W = 5'(COLS);

    state_t      state_q, state_d;
    logic        rdy_meta_q, rdy_s_q;
    logic [7:0]  byte_q, byte_d;
    logic        rd_ack_q;
    logic [8:0]  data_q, data_d;
    logic [19:0] gap_q, gap_d;
    logic [3:0]  col_q, col_d;
    logic        row_q, row_d;
    logic [8:0]  words_q [3];
    logic [8:0]  words_d [3];
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [8:0]  head;

    function automatic logic [8:0] addr_word(input logic [3:0] c, input logic r);
        return {1'b0, 8'h80 | (r ? 8'h40 : 8'h00) | {4'h0, c}};
    endfunction

    assign head = words_q[idx_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_INIT;
            rdy_meta_q <= 1'b0;
            rdy_s_q    <= 1'b0;
            byte_q     <= 8'h00;
            rd_ack_q   <= 1'b0;
            data_q     <= 9'h000;
            gap_q      <= 20'd0;
            col_q      <= 4'd0;
            row_q      <= 1'b0;
            cnt_q      <= 2'd0;
            idx_q      <= 2'd0;
            for (int i = 0; i < 3; i++) words_q[i] <= 9'h000;
        end else begin
            state_q    <= state_d;
            rdy_meta_q <= lcd_if.rx_rdy;
            rdy_s_q    <= rdy_meta_q;
            byte_q     <= byte_d;
            // Registered so the acknowledge crossing back to the receiver is glitch-free
            rd_ack_q   <= (state_d == S_ACK);
            data_q     <= data_d;
            gap_q      <= gap_d;
            col_q      <= col_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            words_q    <= words_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_EMIT;
            S_IDLE:   if (rdy_s_q) state_d = S_ACK;
            S_ACK:    if (!rdy_s_q) state_d = S_DECODE;
            S_DECODE: state_d = (cnt_d == 2'd0) ? S_IDLE : S_EMIT;
            S_EMIT:   state_d = S_WAIT;
            // Leaving at count 1 gives exactly gap+1 cycles between strobes
            S_WAIT:   if (gap_q <= 20'd1) state_d = (idx_q < cnt_q) ? S_EMIT : S_IDLE;
            default:  state_d = S_INIT;
        endcase
    end

    always_comb begin
        byte_d  = byte_q;
        data_d  = data_q;
        gap_d   = gap_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        words_d = words_q;
        case (state_q)
            S_INIT: begin
                words_d[0] = 9'h001;
                cnt_d      = 2'd1;
                idx_d      = 2'd0;
            end
            S_IDLE: if (rdy_s_q) byte_d = lcd_if.rx_data;
            S_DECODE: begin
                cnt_d = 2'd0;
                idx_d = 2'd0;
                if (byte_q >= 8'h20 && byte_q <= 8'h7E) begin
                    words_d[0] = {1'b1, byte_q};
                    cnt_d      = 2'd1;
                    if ({1'b0, col_q} + 5'd1 == COLS_W) begin
                        col_d      = 4'd0;
                        row_d      = ~row_q;
                        words_d[1] = addr_word(4'd0, ~row_q);
                        cnt_d      = 2'd2;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end else begin
                    case (byte_q)
                        8'h0D: begin
                            col_d      = 4'd0;
                            words_d[0] = addr_word(4'd0, row_q);
                            cnt_d      = 2'd1;
                        end
                        8'h0A: begin
                            col_d      = 4'd0;
                            row_d      = ~row_q;
                            words_d[0] = addr_word(4'd0, ~row_q);
                            cnt_d      = 2'd1;
                        end
                        8'h08: if (col_q != 4'd0) begin
                            col_d      = col_q - 4'd1;
                            words_d[0] = addr_word(col_q - 4'd1, row_q);
                            words_d[1] = 9'h120;
                            words_d[2] = addr_word(col_q - 4'd1, row_q);
                            cnt_d      = 2'd3;
                        end
                        8'h0C: begin
                            col_d      = 4'd0;
                            row_d      = 1'b0;
                            words_d[0] = 9'h001;
                            cnt_d      = 2'd1;
                        end
                        default: ;
                    endcase
                end
            end
            S_EMIT: begin
                data_d = head;
                gap_d  = (head == 9'h001) ? CLR_W : GAP_W;
                idx_d  = idx_q + 2'd1;
            end
            S_WAIT: if (gap_q != 20'd0) gap_d = gap_q - 20'd1;
            default: ;
        endcase
    end

    always_comb begin
        lcd_if.wr_en    = (state_q == S_EMIT);
        lcd_if.data_out = (state_q == S_EMIT) ? head : data_q;
        lcd_if.rd_ack   = rd_ack_q;
        busy_o          = (state_q != S_IDLE);
        col_o           = col_q;
        row_o           = row_q;
    end
endmodule
